// File: rtl/ps2_hex_logger.sv
// Buffers incoming codes in a small FIFO and streams each one to a UART TX FIFO as ASCII hex text.
// Optional build macro HEX_LOWERCASE_EN selects lowercase a-f digits.
module ps2_hex_logger #(
  parameter int DATA_W         = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int CODES_PER_LINE = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          clr_ovf,
  output logic                          ovf,
  input  logic                          tx_full,
  output logic                          tx_wr,
  output logic [7:0]                    tx_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [2:0]                    dbg_state
);

  // Handshakes: a code moves into the FIFO on any cycle with in_valid & in_ready;
  // in_valid while in_ready=0 drops the code and sets ovf. A character moves to the
  // UART on any cycle with tx_wr=1, which is only ever raised while tx_full=0.

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int LVW = PW + 1;
  localparam int NW  = (DATA_W > 4) ? $clog2(DATA_W / 4) : 1;
  localparam int LW  = (CODES_PER_LINE > 0) ? $clog2(CODES_PER_LINE + 1) : 1;

`ifdef HEX_LOWERCASE_EN
  localparam logic [7:0] HEX_A = 8'h61;
`else
  localparam logic [7:0] HEX_A = 8'h41;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DIGIT = 3'd1,
    S_END   = 3'd2,
    S_CR    = 3'd3,
    S_LF    = 3'd4
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LVW-1:0]    level_q, level_d;
  logic [DATA_W-1:0] sr_q;
  logic [NW-1:0]     nib_cnt_q;
  logic [LW-1:0]     line_cnt_q;

  logic push, pop, drop, eol;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return HEX_A + {4'h0, n} - 8'd10;
  endfunction

  assign pop      = (state_q == S_IDLE) && (level_q != '0);
  assign in_ready = (level_q < LVW'(FIFO_DEPTH)) | pop;
  assign push     = in_valid & in_ready;
  assign drop     = in_valid & ~in_ready;
  assign eol      = (CODES_PER_LINE != 0) && (line_cnt_q == LW'(CODES_PER_LINE - 1));

  assign busy       = (state_q != S_IDLE) | (level_q != '0);
  assign fifo_level = level_q;
  assign dbg_state  = state_q;

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (!push && pop) level_d = level_q - 1'b1;
  end

  always_comb begin
    tx_wr   = 1'b0;
    tx_data = 8'h20;
    case (state_q)
      S_DIGIT: begin
        tx_data = hex_char(sr_q[DATA_W-1 -: 4]);
        tx_wr   = ~tx_full;
      end
      S_END: tx_wr = ~eol & ~tx_full;
      S_CR: begin
        tx_data = 8'h0D;
        tx_wr   = ~tx_full;
      end
      S_LF: begin
        tx_data = 8'h0A;
        tx_wr   = ~tx_full;
      end
      default: ;
    endcase
  end

  // Storage needs no reset: occupancy and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf      <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      if (drop)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      sr_q       <= '0;
      nib_cnt_q  <= '0;
      line_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            sr_q      <= mem_q[rd_ptr_q];
            nib_cnt_q <= NW'(DATA_W / 4 - 1);
            state_q   <= S_DIGIT;
          end
        end
        S_DIGIT: begin
          if (tx_wr) begin
            sr_q <= sr_q << 4;
            if (nib_cnt_q == '0) state_q <= S_END;
            else                 nib_cnt_q <= nib_cnt_q - 1'b1;
          end
        end
        S_END: begin
          // End of line skips the space and goes straight to CR LF.
          if (eol) begin
            line_cnt_q <= '0;
            state_q    <= S_CR;
          end else if (tx_wr) begin
            line_cnt_q <= line_cnt_q + 1'b1;
            state_q    <= S_IDLE;
          end
        end
        S_CR: if (tx_wr) state_q <= S_LF;
        S_LF: if (tx_wr) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
